fetch_queue: RTL

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue_pkg.sv | 33 +++
 rtl/fetch_queue_ram.sv | 58 +++++
 rtl/fetch_queue.sv | 128 ++++++++++++
 3 files changed

// File: rtl/fetch_queue_pkg.sv
// fetch_queue_wires: shared types for the instruction fetch queue and its storage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: entry_t (49-bit stored halfword), ram_wr_t (one write slot),
// ram_rd_t (head / head+1 read pair), NOP_INSTR, is_compressed().
package fetch_queue_wires;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // One stored halfword: its byte address, the bus error of its fetch word, the data.
  typedef struct packed {
    logic [31:0] pc;
    logic        error;
    logic [15:0] data;
  } entry_t;

  // Write slot j lands at queue index wr_base + j when en is set.
  typedef struct packed {
    logic   en;
    entry_t entry;
  } ram_wr_t;

  // Asynchronous read pair: entries at head and head+1.
  typedef struct packed {
    entry_t head;
    entry_t next;
  } ram_rd_t;

  function automatic logic is_compressed(input logic [15:0] hw);
    return hw[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/fetch_queue_ram.sv
// fetch_queue_ram: halfword storage split into LANES banks of DEPTH/LANES rows.
// Latency: writes land at the clock edge; both reads are combinational.
// Backpressure: none, the caller only enables slots it has room for.
// Ports: clock; wr_base (queue index of slot 0), wr_slot (LANES packed slots);
//        rd_idx (queue index of head); rd (entries at head and head+1).
module fetch_queue_ram
  import fetch_queue_wires::*;
#(
  parameter int LANES = 2,
  parameter int DEPTH = 8
) (
  input  logic                              clock,
  input  logic [$clog2(DEPTH)-1:0]          wr_base,
  input  ram_wr_t [LANES-1:0]               wr_slot,
  input  logic [$clog2(DEPTH)-1:0]          rd_idx,
  output ram_rd_t                           rd
);

  localparam int AW   = $clog2(DEPTH);
  localparam int LW   = $clog2(LANES);
  localparam int ROWS = DEPTH / LANES;
  localparam int RW   = $clog2(ROWS);

  // Queue index i lives in bank i[LW-1:0], row i[AW-1:LW].
  logic [AW-1:0]        n_idx;
  logic [LW-1:0]        h_bank, n_bank;
  logic [RW-1:0]        h_row, n_row;
  entry_t [LANES-1:0]   bank_q;

  assign n_idx  = rd_idx + AW'(1);
  assign h_bank = rd_idx[LW-1:0];
  assign h_row  = rd_idx[AW-1:LW];
  assign n_bank = n_idx[LW-1:0];
  assign n_row  = n_idx[AW-1:LW];

  for (genvar b = 0; b < LANES; b++) begin : g_bank
    entry_t        mem [ROWS];
    logic [LW-1:0] slot;
    logic [RW-1:0] wr_row;

    // Consecutive slots hit consecutive banks, so each bank sees exactly one slot.
    assign slot   = LW'(b) - wr_base[LW-1:0];
    assign wr_row = RW'((wr_base + AW'(slot)) >> LW);

    always_ff @(posedge clock) begin
      if (wr_slot[slot].en) begin
        mem[wr_row] <= wr_slot[slot].entry;
      end
    end

    // head and head+1 are always in different banks, so one read port per bank suffices.
    assign bank_q[b] = mem[(h_bank == LW'(b)) ? h_row : n_row];
  end

  assign rd.head = bank_q[h_bank];
  assign rd.next = bank_q[n_bank];

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: realigns fetch words into a stream of 16/32-bit instructions.
// Latency: 1 cycle from last halfword written to out_valid (0 with FETCH_QUEUE_BYPASS_EN).
// Backpressure: in_ready is registered and drops when fewer than LANES entries are free.
// Macro: FETCH_QUEUE_BYPASS_EN feeds head/head+1 from the incoming word when storage is short.
// Ports: clock, reset (sync, active-low), clear/offset (redirect flush + first-word skip),
//        in_* fetch word handshake, out_* instruction handshake, level (halfwords stored).
module fetch_queue
  import fetch_queue_wires::*;
#(
  parameter int LANES = 2,
  parameter int DEPTH = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        clear,
  input  logic [$clog2(LANES)-1:0]    offset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [31:0]                 in_pc,
  input  logic [16*LANES-1:0]         in_data,
  input  logic                        in_error,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [31:0]                 out_pc,
  output logic [31:0]                 out_instr,
  output logic                        out_error,
  output logic [$clog2(DEPTH):0]      level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int LW = $clog2(LANES);

  logic [PW-1:0]        wptr, rptr, level_next, n_wr, n_rd, avail;
  logic                 skip_pending;
  logic [LW-1:0]        skip_q, skip;
  logic                 in_ready_q;
  logic                 wr_acc, rd_acc;
  ram_wr_t [LANES-1:0]  wr_slot;
  ram_rd_t              rd;
  entry_t               head_e, next_e;
  logic                 head_c;

  assign level    = wptr - rptr;
  assign in_ready = in_ready_q;
  assign skip     = skip_pending ? skip_q : '0;
  assign wr_acc   = in_valid & in_ready_q & ~clear;
  assign n_wr     = wr_acc ? (PW'(LANES) - PW'(skip)) : '0;

  // Compact the surviving lanes (skip..LANES-1) down to slots 0..LANES-1-skip.
  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      wr_slot[j] = '0;
      if (j + int'(skip) < LANES) begin
        wr_slot[j].en          = wr_acc;
        wr_slot[j].entry.pc    = in_pc + 32'((j + int'(skip)) * 2);
        wr_slot[j].entry.error = in_error;
        wr_slot[j].entry.data  = in_data[16*(j + int'(skip)) +: 16];
      end
    end
  end

  fetch_queue_ram #(
    .LANES (LANES),
    .DEPTH (DEPTH)
  ) u_ram (
    .clock   (clock),
    .wr_base (wptr[AW-1:0]),
    .wr_slot (wr_slot),
    .rd_idx  (rptr[AW-1:0]),
    .rd      (rd)
  );

`ifdef FETCH_QUEUE_BYPASS_EN
  // Halfwords still in flight count as available; the missing ones come from the
  // compacted incoming slots in queue order.
  assign avail  = level + n_wr;
  assign head_e = (level != '0) ? rd.head : wr_slot[0].entry;
  assign next_e = (level >= PW'(2)) ? rd.next :
                  (level == PW'(1)) ? wr_slot[0].entry : wr_slot[1].entry;
`else
  assign avail  = level;
  assign head_e = rd.head;
  assign next_e = rd.next;
`endif

  assign head_c    = is_compressed(head_e.data);
  assign out_valid = head_c ? (avail >= PW'(1)) : (avail >= PW'(2));
  assign rd_acc    = out_valid & out_ready & ~clear;
  assign n_rd      = rd_acc ? (head_c ? PW'(1) : PW'(2)) : '0;

  assign level_next = clear ? '0 : (level + n_wr - n_rd);

  always_comb begin
    out_pc    = '0;
    out_instr = NOP_INSTR;
    out_error = 1'b0;
    if (out_valid) begin
      out_pc    = head_e.pc;
      out_instr = head_c ? {16'h0000, head_e.data} : {next_e.data, head_e.data};
      out_error = head_e.error | (~head_c & next_e.error);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wptr         <= '0;
      rptr         <= '0;
      skip_pending <= 1'b0;
      skip_q       <= '0;
      in_ready_q   <= 1'b1;
    end else if (clear) begin
      wptr         <= '0;
      rptr         <= '0;
      skip_pending <= 1'b1;
      skip_q       <= offset;
      in_ready_q   <= 1'b1;
    end else begin
      wptr       <= wptr + n_wr;
      rptr       <= rptr + n_rd;
      in_ready_q <= (PW'(DEPTH) - level_next) >= PW'(LANES);
      if (wr_acc) begin
        skip_pending <= 1'b0;
      end
    end
  end

endmodule
